// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing NUM_REGS software-writable 32-bit registers to fabric logic,
// with byte-enable writes, readback and an optional shadow/commit path for atomic updates.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h01014500,
    parameter logic [31:0] C_HIGHADDR   = 32'h010145FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter int unsigned NUM_REGS     = 4,
    parameter bit          SHADOW_MODE  = 1'b0,
    parameter logic [31:0] INIT_VALUE   = 32'h00000000
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    // Vectors are MSB-first: OPB bit 0 is bit [W-1] here, so whole-vector hookup keeps bus order.
    input  logic [C_OPB_AWIDTH-1:0]   OPB_ABus,
    input  logic [C_OPB_DWIDTH/8-1:0] OPB_BE,
    input  logic [C_OPB_DWIDTH-1:0]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [C_OPB_DWIDTH-1:0]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [NUM_REGS*32-1:0]    user_data_out,
    output logic [NUM_REGS-1:0]       user_data_valid
);

    localparam int unsigned IDX_W = 30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ack_q, ack_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [NUM_REGS-1:0] valid_q, valid_d;
    // Target of bus writes: shadows in shadow mode, actives otherwise.
    logic [31:0]         store_q [NUM_REGS];
    logic [31:0]         store_d [NUM_REGS];
    logic [31:0]         active_c [NUM_REGS];
    logic [15:0]         commit_count_c;

    logic [31:0]      addr_c;
    logic [31:0]      wdata_c;
    logic [3:0]       be_c;
    logic [31:0]      be_mask_c;
    logic [IDX_W-1:0] index_c;
    logic             hit_c;
    logic             start_c;
    logic             is_data_c;
    logic             is_commit_c;
    logic             wr_data_c;
    logic             wr_commit_c;
    logic             rd_c;
    logic             unused_seq_addr_c;

    // Bus decode; the transfer is captured on the IDLE->ACK edge straight from the bus.
    assign addr_c            = 32'(OPB_ABus);
    assign wdata_c           = 32'(OPB_DBus);
    assign be_c              = 4'(OPB_BE);
    assign be_mask_c         = {{8{be_c[3]}}, {8{be_c[2]}}, {8{be_c[1]}}, {8{be_c[0]}}};
    assign index_c           = IDX_W'((addr_c - C_BASEADDR) >> 2);
    assign hit_c             = OPB_select && (addr_c >= C_BASEADDR) && (addr_c <= C_HIGHADDR);
    assign start_c           = (state_q == ST_IDLE) && hit_c;
    assign is_data_c         = index_c < IDX_W'(NUM_REGS);
    assign is_commit_c       = SHADOW_MODE && (index_c == IDX_W'(NUM_REGS));
    assign wr_data_c         = start_c && !OPB_RNW && is_data_c;
    assign wr_commit_c       = start_c && !OPB_RNW && is_commit_c;
    assign rd_c              = start_c && OPB_RNW;
    assign unused_seq_addr_c = OPB_seqAddr;

    always_comb begin : p_next
        state_d = state_q;
        ack_d   = start_c;
        rdata_d = '0;
        valid_d = '0;
        store_d = store_q;

        case (state_q)
            ST_IDLE: if (hit_c) state_d = ST_ACK;
            ST_ACK:  state_d = ST_WAIT;
            ST_WAIT: if (!OPB_select) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_data_c && (index_c == IDX_W'(i))) begin
                store_d[i] = (store_q[i] & ~be_mask_c) | (wdata_c & be_mask_c);
                valid_d[i] = !SHADOW_MODE;
            end
            if (SHADOW_MODE && wr_commit_c) valid_d[i] = 1'b1;
            if (rd_c && (index_c == IDX_W'(i))) rdata_d = store_q[i];
        end
        if (rd_c && is_commit_c) rdata_d = {16'h0000, commit_count_c};
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin : p_regs
        if (OPB_Rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            valid_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) store_q[i] <= INIT_VALUE;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            store_q <= store_d;
        end
    end

    if (SHADOW_MODE) begin : g_shadow
        logic [31:0] active_q [NUM_REGS];
        logic [31:0] active_d [NUM_REGS];
        logic [15:0] commit_count_q, commit_count_d;

        // COMMIT copies every shadow into the actives in a single cycle.
        always_comb begin : p_commit
            active_d       = active_q;
            commit_count_d = commit_count_q;
            if (wr_commit_c) begin
                active_d       = store_q;
                commit_count_d = commit_count_q + 16'd1;
            end
        end

        always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin : p_active
            if (OPB_Rst) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) active_q[i] <= INIT_VALUE;
                commit_count_q <= '0;
            end else begin
                active_q       <= active_d;
                commit_count_q <= commit_count_d;
            end
        end

        assign active_c       = active_q;
        assign commit_count_c = commit_count_q;
    end else begin : g_direct
        assign active_c       = store_q;
        assign commit_count_c = 16'h0000;
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign user_data_out[32*g +: 32] = active_c[g];
    end

    assign user_data_valid = valid_q;
    assign Sl_DBus         = C_OPB_DWIDTH'(rdata_q);
    assign Sl_xferAck      = ack_q;
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench: one direct-mode and one shadow-mode instance driven from a shared bus
// with separate selects, checked against hand-computed vectors.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] B   = 32'h01014500;
    localparam logic [31:0] I_D = 32'h12345678;
    localparam logic [31:0] I_S = 32'h0BADF00D;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  abus;
    logic [3:0]   be;
    logic [31:0]  dbus;
    logic         rnw;
    logic         sel_d, sel_s;
    logic         seq_addr;

    logic [31:0]  dbus_d, dbus_s;
    logic         ack_d, ack_s;
    logic         err_d, err_s, rty_d, rty_s, tout_d, tout_s;
    logic [127:0] udo_d, udo_s;
    logic [3:0]   valid_d, valid_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(
        .NUM_REGS(4), .SHADOW_MODE(1'b0), .INIT_VALUE(I_D)
    ) u_dut_d (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel_d), .OPB_seqAddr(seq_addr),
        .Sl_DBus(dbus_d), .Sl_xferAck(ack_d), .Sl_errAck(err_d), .Sl_retry(rty_d),
        .Sl_toutSup(tout_d), .user_data_out(udo_d), .user_data_valid(valid_d)
    );

    opb_register_bank_ppc2simulink #(
        .NUM_REGS(4), .SHADOW_MODE(1'b1), .INIT_VALUE(I_S)
    ) u_dut_s (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel_s), .OPB_seqAddr(seq_addr),
        .Sl_DBus(dbus_s), .Sl_xferAck(ack_s), .Sl_errAck(err_s), .Sl_retry(rty_s),
        .Sl_toutSup(tout_s), .user_data_out(udo_s), .user_data_valid(valid_s)
    );

    typedef struct {
        bit          sh;
        logic [31:0] addr;
        bit          rnw;
        logic [3:0]  be;
        logic [31:0] data;
        int          hold;
        int          exp_acks;
        logic [31:0] exp_rd;
        logic [3:0]  exp_v;
        logic [127:0] exp_udo;
    } vec_t;

    vec_t vt[$];

    function automatic logic [127:0] pk(input logic [31:0] r0, input logic [31:0] r1,
                                        input logic [31:0] r2, input logic [31:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    function automatic vec_t mk(input bit sh, input logic [31:0] addr, input bit rd,
                                input logic [3:0] bev, input logic [31:0] data, input int hold,
                                input int acks, input logic [31:0] erd, input logic [3:0] ev,
                                input logic [127:0] eudo);
        vec_t v;
        v.sh = sh; v.addr = addr; v.rnw = rd; v.be = bev; v.data = data; v.hold = hold;
        v.exp_acks = acks; v.exp_rd = erd; v.exp_v = ev; v.exp_udo = eudo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one transfer starting just after a rising edge; select held for 'hold' cycles.
    task automatic xfer(input bit sh, input logic [31:0] addr, input bit rd, input logic [3:0] bev,
                        input logic [31:0] data, input int hold,
                        output int acks, output int first_n, output logic [31:0] rdv,
                        output logic [3:0] v_at, output logic [3:0] v_after, output bit leak);
        abus = addr; be = bev; dbus = data; rnw = rd;
        sel_d = !sh; sel_s = sh;
        acks = 0; first_n = -1; rdv = '0; v_at = '0; v_after = '0; leak = 1'b0;
        for (int n = 0; n < hold + 3; n++) begin
            if (n == hold) begin
                sel_d = 1'b0;
                sel_s = 1'b0;
            end
            @(negedge clk);
            if ((sh ? ack_s : ack_d) === 1'b1) begin
                acks++;
                if (first_n < 0) begin
                    first_n = n;
                    rdv     = sh ? dbus_s : dbus_d;
                    v_at    = sh ? valid_s : valid_d;
                end
            end else if ((sh ? dbus_s : dbus_d) !== 32'h0) begin
                leak = 1'b1;
            end
            if (first_n >= 0 && n == first_n + 1) v_after = sh ? valid_s : valid_d;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          acks, first_n;
        logic [31:0] rdv;
        logic [3:0]  v_at, v_after;
        bit          leak;
        string       nm;

        rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b0;
        sel_d = 1'b0; sel_s = 1'b0; seq_addr = 1'b0;

        // Direct-mode instance
        vt.push_back(mk(0, B+32'h4,  0, 4'b1111, 32'hDEADBEEF, 2, 1, 32'h0,        4'b0010, pk(I_D, 32'hDEADBEEF, I_D, I_D)));
        vt.push_back(mk(0, B+32'h4,  1, 4'b1111, 32'h0,        2, 1, 32'hDEADBEEF, 4'b0000, pk(I_D, 32'hDEADBEEF, I_D, I_D)));
        vt.push_back(mk(0, B+32'h4,  0, 4'b0101, 32'h11223344, 2, 1, 32'h0,        4'b0010, pk(I_D, 32'hDE22BE44, I_D, I_D)));
        vt.push_back(mk(0, B+32'h7,  1, 4'b1111, 32'h0,        2, 1, 32'hDE22BE44, 4'b0000, pk(I_D, 32'hDE22BE44, I_D, I_D)));
        vt.push_back(mk(0, B+32'hC,  0, 4'b1000, 32'hCAFEF00D, 2, 1, 32'h0,        4'b1000, pk(I_D, 32'hDE22BE44, I_D, 32'hCA345678)));
        vt.push_back(mk(0, B+32'hC,  0, 4'b1000, 32'hCAFEF00D, 2, 1, 32'h0,        4'b1000, pk(I_D, 32'hDE22BE44, I_D, 32'hCA345678)));
        vt.push_back(mk(0, B+32'h10, 0, 4'b1111, 32'hFFFFFFFF, 2, 1, 32'h0,        4'b0000, pk(I_D, 32'hDE22BE44, I_D, 32'hCA345678)));
        vt.push_back(mk(0, B+32'h10, 1, 4'b1111, 32'h0,        2, 1, 32'h0,        4'b0000, pk(I_D, 32'hDE22BE44, I_D, 32'hCA345678)));
        vt.push_back(mk(0, B+32'hFC, 0, 4'b1111, 32'hFFFFFFFF, 2, 1, 32'h0,        4'b0000, pk(I_D, 32'hDE22BE44, I_D, 32'hCA345678)));
        vt.push_back(mk(0, B+32'hFC, 1, 4'b1111, 32'h0,        2, 1, 32'h0,        4'b0000, pk(I_D, 32'hDE22BE44, I_D, 32'hCA345678)));
        vt.push_back(mk(0, B,        1, 4'b1111, 32'h0,        5, 1, I_D,          4'b0000, pk(I_D, 32'hDE22BE44, I_D, 32'hCA345678)));
        vt.push_back(mk(0, B+32'h100,0, 4'b1111, 32'hFFFFFFFF, 2, 0, 32'h0,        4'b0000, pk(I_D, 32'hDE22BE44, I_D, 32'hCA345678)));
        vt.push_back(mk(0, B-32'h4,  0, 4'b1111, 32'hFFFFFFFF, 2, 0, 32'h0,        4'b0000, pk(I_D, 32'hDE22BE44, I_D, 32'hCA345678)));
        // Shadow-mode instance
        vt.push_back(mk(1, B,        0, 4'b1111, 32'hA5A5A5A5, 2, 1, 32'h0,        4'b0000, pk(I_S, I_S, I_S, I_S)));
        vt.push_back(mk(1, B+32'h8,  0, 4'b1111, 32'h5A5A5A5A, 2, 1, 32'h0,        4'b0000, pk(I_S, I_S, I_S, I_S)));
        vt.push_back(mk(1, B,        1, 4'b1111, 32'h0,        2, 1, 32'hA5A5A5A5, 4'b0000, pk(I_S, I_S, I_S, I_S)));
        vt.push_back(mk(1, B+32'h10, 0, 4'b1111, 32'hFFFFFFFF, 2, 1, 32'h0,        4'b1111, pk(32'hA5A5A5A5, I_S, 32'h5A5A5A5A, I_S)));
        vt.push_back(mk(1, B+32'h10, 1, 4'b1111, 32'h0,        2, 1, 32'h1,        4'b0000, pk(32'hA5A5A5A5, I_S, 32'h5A5A5A5A, I_S)));
        vt.push_back(mk(1, B+32'h4,  0, 4'b0011, 32'h0000FFFF, 2, 1, 32'h0,        4'b0000, pk(32'hA5A5A5A5, I_S, 32'h5A5A5A5A, I_S)));
        vt.push_back(mk(1, B+32'h4,  1, 4'b1111, 32'h0,        2, 1, 32'h0BADFFFF, 4'b0000, pk(32'hA5A5A5A5, I_S, 32'h5A5A5A5A, I_S)));
        vt.push_back(mk(1, B+32'h10, 0, 4'b0000, 32'h0,        2, 1, 32'h0,        4'b1111, pk(32'hA5A5A5A5, 32'h0BADFFFF, 32'h5A5A5A5A, I_S)));
        vt.push_back(mk(1, B+32'h10, 1, 4'b1111, 32'h0,        2, 1, 32'h2,        4'b0000, pk(32'hA5A5A5A5, 32'h0BADFFFF, 32'h5A5A5A5A, I_S)));
        vt.push_back(mk(1, B+32'h14, 1, 4'b1111, 32'h0,        2, 1, 32'h0,        4'b0000, pk(32'hA5A5A5A5, 32'h0BADFFFF, 32'h5A5A5A5A, I_S)));

        repeat (2) @(posedge clk);
        #1;
        chk("rst udo_d",   udo_d,   pk(I_D, I_D, I_D, I_D));
        chk("rst udo_s",   udo_s,   pk(I_S, I_S, I_S, I_S));
        chk("rst ack_d",   128'(ack_d),   128'(0));
        chk("rst dbus_d",  128'(dbus_d),  128'(0));
        chk("rst valid_d", 128'(valid_d), 128'(0));
        chk("rst valid_s", 128'(valid_s), 128'(0));
        chk("tied outs",   128'({err_d, rty_d, tout_d, err_s, rty_s, tout_s}), 128'(0));
        rst = 1'b0;

        foreach (vt[k]) begin
            xfer(vt[k].sh, vt[k].addr, vt[k].rnw, vt[k].be, vt[k].data, vt[k].hold,
                 acks, first_n, rdv, v_at, v_after, leak);
            nm = $sformatf("v%0d", k);
            chk({nm, " acks"}, 128'(acks), 128'(vt[k].exp_acks));
            if (vt[k].exp_acks > 0) begin
                chk({nm, " ack_cycle"}, 128'(first_n), 128'(1));
                if (vt[k].rnw) chk({nm, " rdata"}, 128'(rdv), 128'(vt[k].exp_rd));
                chk({nm, " valid"},      128'(v_at),    128'(vt[k].exp_v));
                chk({nm, " valid_next"}, 128'(v_after), 128'(0));
            end
            chk({nm, " dbus_idle"}, 128'(leak), 128'(0));
            chk({nm, " udo"}, vt[k].sh ? udo_s : udo_d, vt[k].exp_udo);
        end

        // Reset asserted while a write is in its ACK cycle.
        abus = B + 32'h8; be = 4'b1111; dbus = 32'h77777777; rnw = 1'b0; sel_d = 1'b1;
        @(posedge clk);
        #1;
        chk("abort ack_before", 128'(ack_d), 128'(1));
        rst = 1'b1;
        #1;
        chk("abort ack",   128'(ack_d),   128'(0));
        chk("abort dbus",  128'(dbus_d),  128'(0));
        chk("abort valid", 128'(valid_d), 128'(0));
        chk("abort udo_d", udo_d, pk(I_D, I_D, I_D, I_D));
        chk("abort udo_s", udo_s, pk(I_S, I_S, I_S, I_S));
        sel_d = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        xfer(0, B + 32'h8, 1, 4'b1111, 32'h0, 2, acks, first_n, rdv, v_at, v_after, leak);
        chk("post_rst acks",  128'(acks),    128'(1));
        chk("post_rst cycle", 128'(first_n), 128'(1));
        chk("post_rst rdata", 128'(rdv),     128'(I_D));
        xfer(1, B + 32'h10, 1, 4'b1111, 32'h0, 2, acks, first_n, rdv, v_at, v_after, leak);
        chk("post_rst commit_count", 128'(rdv), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
